// File: rtl/sprite_pos_ctrl.sv
// sprite_pos_ctrl: sprite position controller and pixel-address generator; define SPRITE_WRAP_EN to wrap at screen edges instead of clamping
module sprite_pos_ctrl #(
   parameter int SCR_W  = 640,
   parameter int SCR_H  = 480,
   parameter int SPR_W  = 32,
   parameter int SPR_H  = 32,
   parameter int STEP   = 20,
   parameter int X0     = 320,
   parameter int Y0     = 240,
   parameter int ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              key_ready_i,
   input  logic [4:0]        key_code_i,
   input  logic              kb_ready_i,
   input  logic [7:0]        kb_code_i,
   input  logic              frame_sync_i,
   input  logic [9:0]        col_addr_i,
   input  logic [8:0]        row_addr_i,
   output logic [9:0]        pos_x_o,
   output logic [8:0]        pos_y_o,
   output logic              hit_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic              cmd_drop_o
);
   typedef enum logic [2:0] {D_NONE, D_LEFT, D_RIGHT, D_UP, D_DOWN} dir_e;
   localparam logic [10:0] MAX_X  = 11'(SCR_W - SPR_W);
   localparam logic [9:0]  MAX_Y  = 10'(SCR_H - SPR_H);
   localparam logic [10:0] STEP_X = 11'(STEP);
   localparam logic [9:0]  STEP_Y = 10'(STEP);
   logic              kp_prev_q, kb_prev_q;
   dir_e              pend_q, pend_d, kp_dir, kb_dir, kb_eff, cmd;
   logic              drop_d, cmd_drop_q;
   logic [9:0]        pos_x_q, pos_x_d, disp_x_q;
   logic [8:0]        pos_y_q, pos_y_d, disp_y_q;
   logic [10:0]       x_ext, x_sum, x_dec, x_inc, col_ext, dx_ext;
   logic [9:0]        y_ext, y_sum, y_dec, y_inc, row_ext, dy_ext;
   logic [9:0]        col_off;
   logic [8:0]        row_off;
   logic              hit_q, hit_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

   function automatic dir_e decode(input logic [7:0] code);
      return code == 8'h0C ? D_LEFT : code == 8'h0E ? D_RIGHT :
             code == 8'h09 ? D_UP : code == 8'h11 ? D_DOWN : D_NONE;
   endfunction

   // Edge-detect both sources; keypad wins, a colliding keyboard command waits one-deep in pending
   always_comb begin
      kp_dir = (key_ready_i && !kp_prev_q) ? decode({3'b000, key_code_i}) : D_NONE;
      kb_dir = (kb_ready_i && !kb_prev_q) ? decode(kb_code_i) : D_NONE;
      kb_eff = kb_dir != D_NONE ? kb_dir : pend_q;
      drop_d = kb_dir != D_NONE && pend_q != D_NONE;
      cmd    = kp_dir != D_NONE ? kp_dir : kb_eff;
      pend_d = kp_dir != D_NONE ? kb_eff : D_NONE;
   end

   // Next position with one extra bit of headroom so the boundary tests cannot overflow
   always_comb begin
      x_ext = {1'b0, pos_x_q};
      y_ext = {1'b0, pos_y_q};
      x_sum = x_ext + STEP_X;
      y_sum = y_ext + STEP_Y;
`ifdef SPRITE_WRAP_EN
      x_dec = x_ext < STEP_X ? x_ext + MAX_X + 11'd1 - STEP_X : x_ext - STEP_X;
      x_inc = x_sum > MAX_X ? x_sum - MAX_X - 11'd1 : x_sum;
      y_dec = y_ext < STEP_Y ? y_ext + MAX_Y + 10'd1 - STEP_Y : y_ext - STEP_Y;
      y_inc = y_sum > MAX_Y ? y_sum - MAX_Y - 10'd1 : y_sum;
`else
      x_dec = x_ext < STEP_X ? 11'd0 : x_ext - STEP_X;
      x_inc = x_sum > MAX_X ? MAX_X : x_sum;
      y_dec = y_ext < STEP_Y ? 10'd0 : y_ext - STEP_Y;
      y_inc = y_sum > MAX_Y ? MAX_Y : y_sum;
`endif
      pos_x_d = cmd == D_LEFT ? 10'(x_dec) : cmd == D_RIGHT ? 10'(x_inc) : pos_x_q;
      pos_y_d = cmd == D_UP ? 9'(y_dec) : cmd == D_DOWN ? 9'(y_inc) : pos_y_q;
   end

   // Hit test and ROM address against the frame-stable display copy
   always_comb begin
      col_ext    = {1'b0, col_addr_i};
      dx_ext     = {1'b0, disp_x_q};
      row_ext    = {1'b0, row_addr_i};
      dy_ext     = {1'b0, disp_y_q};
      col_off    = col_addr_i - disp_x_q;
      row_off    = row_addr_i - disp_y_q;
      hit_d      = col_ext >= dx_ext && col_ext < dx_ext + 11'(SPR_W) &&
                   row_ext >= dy_ext && row_ext < dy_ext + 10'(SPR_H);
      rom_addr_d = hit_d ? ADDR_W'(row_off * SPR_W + col_off) : '0;
   end

   // State: edge history, pending command, live and display positions, registered render outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         kp_prev_q  <= 1'b0;
         kb_prev_q  <= 1'b0;
         pend_q     <= D_NONE;
         cmd_drop_q <= 1'b0;
         pos_x_q    <= 10'(X0);
         pos_y_q    <= 9'(Y0);
         disp_x_q   <= 10'(X0);
         disp_y_q   <= 9'(Y0);
         hit_q      <= 1'b0;
         rom_addr_q <= '0;
      end else begin
         kp_prev_q  <= key_ready_i;
         kb_prev_q  <= kb_ready_i;
         pend_q     <= pend_d;
         cmd_drop_q <= drop_d;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         if (frame_sync_i) begin
            disp_x_q <= pos_x_q;
            disp_y_q <= pos_y_q;
         end
         hit_q      <= hit_d;
         rom_addr_q <= rom_addr_d;
      end
   end

   assign pos_x_o    = pos_x_q;
   assign pos_y_o    = pos_y_q;
   assign hit_o      = hit_q;
   assign rom_addr_o = rom_addr_q;
   assign cmd_drop_o = cmd_drop_q;
endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// tb_sprite_pos_ctrl: vector table, corner sequences and randomized model check for sprite_pos_ctrl
module tb_sprite_pos_ctrl;
   localparam int SPR = 32;
   localparam int STP = 20;
   localparam int MAXX = 608;
   localparam int MAXY = 448;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_ready = 1'b0;
   logic [4:0] key_code = '0;
   logic       kb_ready = 1'b0;
   logic [7:0] kb_code = '0;
   logic       frame_sync = 1'b0;
   logic [9:0] col_addr = '0;
   logic [8:0] row_addr = '0;
   logic [9:0] pos_x;
   logic [8:0] pos_y;
   logic       hit;
   logic [9:0] rom_addr;
   logic       cmd_drop;
   int n_cmp = 0;
   int n_err = 0;

   sprite_pos_ctrl dut (
      .clk_i(clk), .rst_ni(rst_n), .key_ready_i(key_ready), .key_code_i(key_code),
      .kb_ready_i(kb_ready), .kb_code_i(kb_code), .frame_sync_i(frame_sync),
      .col_addr_i(col_addr), .row_addr_i(row_addr), .pos_x_o(pos_x), .pos_y_o(pos_y),
      .hit_o(hit), .rom_addr_o(rom_addr), .cmd_drop_o(cmd_drop)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic kr; logic [4:0] kc; logic br; logic [7:0] bc; logic fs;
      int col; int row; int ex; int ey; int eh; int ea; int ed;
   } vec_t;
   vec_t tbl[19];

   // behavioural model state
   int m_x, m_y, m_dx, m_dy;
   logic m_kl, m_bl;
   int pq[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      key_ready = 1'b0;
      kb_ready = 1'b0;
      frame_sync = 1'b0;
      col_addr = '0;
      row_addr = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic press(input logic [4:0] code);
      key_code = code;
      key_ready = 1'b1;
      tick();
      key_ready = 1'b0;
      tick();
   endtask

   function automatic int code_dir(input int code);
      return code == 'h0C ? 0 : code == 'h0E ? 1 : code == 'h09 ? 2 : code == 'h11 ? 3 : -1;
   endfunction

   function automatic int move(input int p, input int d, input int maxv);
      int n = p + d;
`ifdef SPRITE_WRAP_EN
      return ((n % (maxv + 1)) + maxv + 1) % (maxv + 1);
`else
      return n < 0 ? 0 : (n > maxv ? maxv : n);
`endif
   endfunction

   task automatic m_apply(input int d);
      if (d == 0) m_x = move(m_x, -STP, MAXX);
      if (d == 1) m_x = move(m_x, STP, MAXX);
      if (d == 2) m_y = move(m_y, -STP, MAXY);
      if (d == 3) m_y = move(m_y, STP, MAXY);
   endtask

   function automatic int pick_code();
      int r = int'($urandom % 6);
      return r == 0 ? 'h0C : r == 1 ? 'h0E : r == 2 ? 'h09 : r == 3 ? 'h11 : int'($urandom % 256);
   endfunction

   initial begin
      int ex, ey, eh, ea, ed, kp, kb, c, r;
      tbl[0]  = '{1, 5'h0E, 0, 8'h00, 0,   0,   0, 340, 240, 0,    0, 0};
      tbl[1]  = '{1, 5'h0E, 0, 8'h00, 0,   0,   0, 340, 240, 0,    0, 0};
      tbl[2]  = '{0, 5'h0E, 0, 8'h00, 0,   0,   0, 340, 240, 0,    0, 0};
      tbl[3]  = '{1, 5'h0C, 1, 8'h09, 0,   0,   0, 320, 240, 0,    0, 0};
      tbl[4]  = '{1, 5'h0C, 1, 8'h09, 0,   0,   0, 320, 220, 0,    0, 0};
      tbl[5]  = '{0, 5'h00, 0, 8'h00, 0,   0,   0, 320, 220, 0,    0, 0};
      tbl[6]  = '{0, 5'h00, 0, 8'h00, 0, 321, 242, 320, 220, 1,   65, 0};
      tbl[7]  = '{0, 5'h00, 0, 8'h00, 1, 321, 242, 320, 220, 1,   65, 0};
      tbl[8]  = '{0, 5'h00, 0, 8'h00, 0, 321, 242, 320, 220, 1,  705, 0};
      tbl[9]  = '{0, 5'h00, 0, 8'h00, 0, 352, 242, 320, 220, 0,    0, 0};
      tbl[10] = '{0, 5'h00, 0, 8'h00, 0, 351, 251, 320, 220, 1, 1023, 0};
      tbl[11] = '{0, 5'h00, 0, 8'h00, 0, 319, 251, 320, 220, 0,    0, 0};
      tbl[12] = '{0, 5'h00, 1, 8'h11, 0, 321, 242, 320, 240, 1,  705, 0};
      tbl[13] = '{0, 5'h00, 0, 8'h11, 0, 321, 242, 320, 240, 1,  705, 0};
      tbl[14] = '{0, 5'h00, 1, 8'h8C, 0,   0,   0, 320, 240, 0,    0, 0};
      tbl[15] = '{0, 5'h00, 0, 8'h00, 0,   0,   0, 320, 240, 0,    0, 0};
      tbl[16] = '{1, 5'h11, 0, 8'h00, 0,   0,   0, 320, 260, 0,    0, 0};
      tbl[17] = '{0, 5'h00, 0, 8'h00, 0,   0,   0, 320, 260, 0,    0, 0};
      tbl[18] = '{0, 5'h00, 0, 8'h00, 0, 320, 219, 320, 260, 0,    0, 0};

      do_reset();
      chk("reset.x", int'(pos_x), 320);
      chk("reset.y", int'(pos_y), 240);
      chk("reset.hit", int'(hit), 0);
      chk("reset.addr", int'(rom_addr), 0);
      chk("reset.drop", int'(cmd_drop), 0);

      foreach (tbl[i]) begin
         key_ready = tbl[i].kr; key_code = tbl[i].kc;
         kb_ready = tbl[i].br; kb_code = tbl[i].bc; frame_sync = tbl[i].fs;
         col_addr = 10'(tbl[i].col); row_addr = 9'(tbl[i].row);
         tick();
         chk($sformatf("vec%0d.x", i), int'(pos_x), tbl[i].ex);
         chk($sformatf("vec%0d.y", i), int'(pos_y), tbl[i].ey);
         chk($sformatf("vec%0d.hit", i), int'(hit), tbl[i].eh);
         chk($sformatf("vec%0d.addr", i), int'(rom_addr), tbl[i].ea);
         chk($sformatf("vec%0d.drop", i), int'(cmd_drop), tbl[i].ed);
      end

      do_reset();
      key_code = 5'h0E;
      key_ready = 1'b1;
      tick();
      chk("hold.first", int'(pos_x), 340);
      repeat (100) tick();
      chk("hold.after100", int'(pos_x), 340);
      key_ready = 1'b0;
      tick();

      do_reset();
      repeat (16) press(5'h0C);
      chk("left.to0", int'(pos_x), 0);
      press(5'h0C);
`ifdef SPRITE_WRAP_EN
      chk("left.edge", int'(pos_x), 589);
`else
      chk("left.edge", int'(pos_x), 0);
`endif
      key_code = 5'h0E;
      key_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async.x", int'(pos_x), 320);
      chk("async.y", int'(pos_y), 240);
      chk("async.hit", int'(hit), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("async.level_fires", int'(pos_x), 340);
      key_ready = 1'b0;

      do_reset();
      repeat (14) press(5'h0E);
      chk("right.to600", int'(pos_x), 600);
      press(5'h0E);
`ifdef SPRITE_WRAP_EN
      chk("right.edge1", int'(pos_x), 11);
      press(5'h0E);
      chk("right.edge2", int'(pos_x), 31);
`else
      chk("right.edge1", int'(pos_x), 608);
      press(5'h0E);
      chk("right.edge2", int'(pos_x), 608);
`endif

      do_reset();
      repeat (12) press(5'h09);
      chk("up.to0", int'(pos_y), 0);
      press(5'h09);
`ifdef SPRITE_WRAP_EN
      chk("up.edge", int'(pos_y), 429);
`else
      chk("up.edge", int'(pos_y), 0);
`endif
      do_reset();
      repeat (10) press(5'h11);
      chk("down.to440", int'(pos_y), 440);
      press(5'h11);
`ifdef SPRITE_WRAP_EN
      chk("down.edge", int'(pos_y), 11);
`else
      chk("down.edge", int'(pos_y), 448);
`endif

      do_reset();
      m_x = 320; m_y = 240; m_dx = 320; m_dy = 240;
      m_kl = 1'b0; m_bl = 1'b0;
      pq.delete();
      for (int n = 0; n < 3000; n++) begin
         if (!key_ready) key_code = 5'(pick_code());
         if (!kb_ready) kb_code = 8'(pick_code());
         if ($urandom % 3 == 0) key_ready = !key_ready;
         if ($urandom % 3 == 0) kb_ready = !kb_ready;
         frame_sync = ($urandom % 30) == 0;
         c = ($urandom % 2) ? m_dx + int'($urandom % 40) - 4 : int'($urandom % 640);
         r = ($urandom % 2) ? m_dy + int'($urandom % 40) - 4 : int'($urandom % 480);
         c = c < 0 ? 0 : (c > 1023 ? 1023 : c);
         r = r < 0 ? 0 : (r > 511 ? 511 : r);
         col_addr = 10'(c);
         row_addr = 9'(r);
         eh = (c >= m_dx && c < m_dx + SPR && r >= m_dy && r < m_dy + SPR) ? 1 : 0;
         ea = eh ? (r - m_dy) * SPR + (c - m_dx) : 0;
         kp = (key_ready && !m_kl) ? code_dir(int'(key_code)) : -1;
         kb = (kb_ready && !m_bl) ? code_dir(int'(kb_code)) : -1;
         ed = (kb >= 0 && pq.size() > 0) ? 1 : 0;
         if (frame_sync) begin
            m_dx = m_x;
            m_dy = m_y;
         end
         if (kp >= 0) begin
            m_apply(kp);
            if (kb >= 0) begin
               pq.delete();
               pq.push_back(kb);
            end
         end else if (kb >= 0) begin
            pq.delete();
            m_apply(kb);
         end else if (pq.size() > 0) begin
            m_apply(pq.pop_front());
         end
         m_kl = key_ready;
         m_bl = kb_ready;
         ex = m_x;
         ey = m_y;
         tick();
         n_cmp++;
         if (int'(pos_x) != ex || int'(pos_y) != ey || int'(hit) != eh ||
             int'(rom_addr) != ea || int'(cmd_drop) != ed) begin
            n_err++;
            $display("FAIL rand%0d: got x=%0d y=%0d hit=%0d addr=%0d drop=%0d expected x=%0d y=%0d hit=%0d addr=%0d drop=%0d",
                     n, pos_x, pos_y, hit, rom_addr, cmd_drop, ex, ey, eh, ea, ed);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
